// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM address and
// registers opcode/immediate into the IF/ID register, with stall, branch and halt control.
module fetch_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LENGTH = 256,
  parameter int unsigned RESET_VEC = 0,
  parameter logic [WIDTH-1:0] IMM_MASK = 8'hC0,
  parameter logic [WIDTH-1:0] IMM_MATCH = 8'hC0,
  localparam int unsigned ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_instr,
  input  logic [WIDTH-1:0]      rom_imm,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  halt,
  output logic                  if_valid,
  output logic [WIDTH-1:0]      if_instr,
  output logic [WIDTH-1:0]      if_imm,
  output logic                  if_has_imm,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_next_pc,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH:0]   LEN_W    = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VEC);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  has_imm;
  logic [ADDR_WIDTH:0]   sum;
  logic [ADDR_WIDTH-1:0] pc_step;

  // One extra bit on the sum so non-power-of-two depths still wrap modulo LENGTH.
  always_comb begin
    has_imm = (rom_instr & IMM_MASK) == IMM_MATCH;
    sum     = {1'b0, pc} + (has_imm ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
    if (sum >= LEN_W) pc_step = ADDR_WIDTH'(sum - LEN_W);
    else              pc_step = ADDR_WIDTH'(sum);
  end

  assign rom_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_imm     <= '0;
      if_has_imm <= 1'b0;
      if_pc      <= '0;
      if_next_pc <= '0;
      halted     <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
          if (branch_en) pc <= branch_addr;
        end
        RUN: begin
          if (branch_en) begin
            pc       <= branch_addr;
            if_valid <= 1'b0;
          end else if (halt) begin
            state    <= HALT;
            if_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (!stall) begin
            if_instr   <= rom_instr;
            if_imm     <= rom_imm;
            if_has_imm <= has_imm;
            if_pc      <= pc;
            if_next_pc <= pc_step;
            if_valid   <= 1'b1;
            pc         <= pc_step;
          end
        end
        HALT: begin
          if (branch_en) begin
            pc       <= branch_addr;
            halted   <= 1'b0;
            if_valid <= 1'b0;
            state    <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences,
// then randomized control and ROM contents against a behavioural fetch model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rom_addr;
  logic [7:0] rom_instr;
  logic [7:0] rom_imm;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_addr;
  logic       halt;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic       if_has_imm;
  logic [7:0] if_pc;
  logic [7:0] if_next_pc;
  logic       halted;

  logic [7:0] rom [256];
  logic [7:0] imm_addr;

  assign imm_addr  = rom_addr + 8'd1;
  assign rom_instr = rom[rom_addr];
  assign rom_imm   = rom[imm_addr];

  fetch_unit #(
    .WIDTH(8),
    .LENGTH(256),
    .RESET_VEC(0),
    .IMM_MASK(8'hC0),
    .IMM_MATCH(8'hC0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .rom_imm(rom_imm),
    .stall(stall),
    .branch_en(branch_en),
    .branch_addr(branch_addr),
    .halt(halt),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_imm(if_imm),
    .if_has_imm(if_has_imm),
    .if_pc(if_pc),
    .if_next_pc(if_next_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pc;
  bit m_boot, m_halted, m_valid, m_has;
  int m_instr, m_imm, m_ifpc, m_next;

  task automatic model_reset();
    m_pc = 0; m_boot = 1; m_halted = 0; m_valid = 0; m_has = 0;
    m_instr = 0; m_imm = 0; m_ifpc = 0; m_next = 0;
  endtask

  task automatic model_step();
    bit imm;
    int nxt;
    imm = ((rom[m_pc] & 8'hC0) == 8'hC0);
    nxt = (m_pc + (imm ? 2 : 1)) % 256;
    if (m_boot) begin
      m_boot = 0;
      if (branch_en) m_pc = branch_addr;
    end else if (m_halted) begin
      if (branch_en) begin m_pc = branch_addr; m_halted = 0; m_valid = 0; end
    end else if (branch_en) begin
      m_pc = branch_addr; m_valid = 0;
    end else if (halt) begin
      m_halted = 1; m_valid = 0;
    end else if (!stall) begin
      m_instr = rom[m_pc];
      m_imm   = rom[(m_pc + 1) % 256];
      m_has   = imm;
      m_ifpc  = m_pc;
      m_next  = nxt;
      m_valid = 1;
      m_pc    = nxt;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " rom_addr"},   32'(rom_addr),   32'(m_pc));
    chk({tag, " if_valid"},   32'(if_valid),   32'(m_valid));
    chk({tag, " halted"},     32'(halted),     32'(m_halted));
    chk({tag, " if_instr"},   32'(if_instr),   32'(m_instr));
    chk({tag, " if_imm"},     32'(if_imm),     32'(m_imm));
    chk({tag, " if_has_imm"}, 32'(if_has_imm), 32'(m_has));
    chk({tag, " if_pc"},      32'(if_pc),      32'(m_ifpc));
    chk({tag, " if_next_pc"}, 32'(if_next_pc), 32'(m_next));
  endtask

  task automatic drive(bit s, bit b, logic [7:0] ba, bit h);
    stall = s; branch_en = b; branch_addr = ba; halt = h;
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         st;
    bit         br;
    logic [7:0] ba;
    bit         h;
    bit         exp_valid;
    logic [7:0] exp_ifpc;
    logic [7:0] exp_ra;
    bit         exp_halted;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) rom[i] = 8'h01;
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'hC5; rom[3] = 8'hAA; rom[4] = 8'h03;
    model_reset();

    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0}); // boot bubble
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h01, 8'h02, 0});
    for (int i = 0; i < 3; i++) vecs.push_back(vec_t'{1, 0, 8'h00, 0, 1, 8'h01, 8'h02, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h02, 8'h04, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h04, 8'h05, 0});
    vecs.push_back(vec_t'{1, 1, 8'h40, 0, 0, 8'h04, 8'h40, 0}); // branch under stall
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h40, 8'h41, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h40, 8'h41, 1}); // halt
    for (int i = 0; i < 10; i++)
      vecs.push_back(vec_t'{bit'(i % 2), 0, 8'h00, bit'(i % 3 == 0), 0, 8'h40, 8'h41, 1});
    vecs.push_back(vec_t'{0, 1, 8'h10, 0, 0, 8'h40, 8'h10, 0}); // resume
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h10, 8'h11, 0});

    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].ba, vecs[i].h);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_valid", i),  32'(if_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d tbl_if_pc", i),  32'(if_pc),    32'(vecs[i].exp_ifpc));
      chk($sformatf("vec%0d tbl_addr", i),   32'(rom_addr), 32'(vecs[i].exp_ra));
      chk($sformatf("vec%0d tbl_halted", i), 32'(halted),   32'(vecs[i].exp_halted));
      if (i == 6) begin
        chk("seq imm", 32'(if_imm), 32'h0000_00AA);
        chk("seq has_imm", 32'(if_has_imm), 32'd1);
        chk("seq next_pc", 32'(if_next_pc), 32'd4);
      end
    end

    // Wrap-around with a 2-byte instruction at the last address
    rom[8'hFF] = 8'hC0; rom[0] = 8'h7E;
    drive(0, 1, 8'hFF, 0); tick("wrap br");
    drive(0, 0, 8'h00, 0); tick("wrap2");
    chk("wrap2 if_pc", 32'(if_pc), 32'h0000_00FF);
    chk("wrap2 if_imm", 32'(if_imm), 32'h0000_007E);
    chk("wrap2 has_imm", 32'(if_has_imm), 32'd1);
    chk("wrap2 next_pc", 32'(if_next_pc), 32'd1);
    chk("wrap2 rom_addr", 32'(rom_addr), 32'd1);
    rom[8'hFF] = 8'h01;
    drive(0, 1, 8'hFF, 0); tick("wrap br");
    drive(0, 0, 8'h00, 0); tick("wrap1");
    chk("wrap1 rom_addr", 32'(rom_addr), 32'd0);
    chk("wrap1 next_pc", 32'(if_next_pc), 32'd0);

    // Asynchronous reset between edges
    drive(0, 1, 8'h23, 0); tick("pre-rst br");
    drive(0, 0, 8'h00, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rom_addr", 32'(rom_addr), 32'd0);
    chk("async if_valid", 32'(if_valid), 32'd0);
    model_reset();
    check_all("async");
    @(negedge clk);
    rst = 1'b0;
    tick("post-rst boot");
    chk("post-rst bubble", 32'(if_valid), 32'd0);
    tick("post-rst fetch");
    chk("post-rst first", 32'(if_valid), 32'd1);
    chk("post-rst if_pc", 32'(if_pc), 32'd0);

    // Randomized control and ROM contents
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rand rst");
        rst = 1'b0;
      end
      drive(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 9) == 0),
            8'($urandom), bit'($urandom_range(0, 19) == 0));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM address. Samples the ROM opcode and immediate bytes into an IF/ID pipeline register.
- Advances the PC by 1 or 2 bytes, depending on whether the opcode carries an immediate.
- Handles decode stalls, taken branches/jumps from execute, and a halt state.

Parameters:
- WIDTH, 8, instruction/immediate byte width; must match the ROM.
- LENGTH, 256, ROM depth in bytes. ADDR_WIDTH = $clog2(LENGTH) is a derived localparam.
- RESET_VEC, 0, PC value loaded on reset.
- IMM_MASK, 8'hC0, opcode bits examined for immediate detection.
- IMM_MATCH, 8'hC0, opcode has an immediate when (opcode & IMM_MASK) == IMM_MATCH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  ROM address; equals the PC register.
- rom_instr  in  WIDTH  ROM opcode byte at rom_addr, combinational.
- rom_imm  in  WIDTH  ROM byte at rom_addr+1, combinational.
- stall  in  1  decode cannot accept; hold PC and the IF/ID register.
- branch_en  in  1  taken branch/jump; redirect the PC.
- branch_addr  in  ADDR_WIDTH  redirect target.
- halt  in  1  request to stop fetching.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instr  out  WIDTH  registered opcode.
- if_imm  out  WIDTH  registered immediate; don't-care when if_has_imm=0.
- if_has_imm  out  1  registered immediate-present flag.
- if_pc  out  ADDR_WIDTH  address of the registered opcode.
- if_next_pc  out  ADDR_WIDTH  address of the following instruction (link value for calls).
- halted  out  1  high while in HALT.

Behaviour:
- Reset, asynchronous: state=BOOT, pc=RESET_VEC, if_valid=0, if_instr=0, if_imm=0, if_has_imm=0, if_pc=0, if_next_pc=0, halted=0.
- Reset asserted mid-operation overrides everything on the same cycle.
- has_imm = ((rom_instr & IMM_MASK) == IMM_MATCH), computed combinationally.
- step = 1 + has_imm.
- PC arithmetic is modulo LENGTH:
  - pc+step wraps from LENGTH-1 to 0, or to 1 when step=2 at LENGTH-1.
  - The immediate of an opcode at LENGTH-1 is rom[0], supplied by the ROM's own address wrap.
- State machine, evaluated each rising edge. Priority: branch_en > halt > stall.
  - BOOT:
    - if_valid stays 0 and pc is unchanged.
    - Next state is RUN. This gives the ROM one settle cycle after reset.
    - branch_en in BOOT loads pc=branch_addr and still goes to RUN.
  - RUN:
    - branch_en: pc<=branch_addr, if_valid<=0 (squashes the wrong-path fetch). Stays RUN. This is a 1-bubble penalty, and it applies even when stall=1.
    - else halt: go to HALT, if_valid<=0, pc held, halted<=1.
    - else stall: pc and all if_* outputs held unchanged, including if_valid.
    - else: if_instr<=rom_instr, if_imm<=rom_imm, if_has_imm<=has_imm, if_pc<=pc, if_next_pc<=pc+step, if_valid<=1, pc<=pc+step.
  - HALT:
    - pc and the if_* data outputs are frozen, if_valid=0, halted=1.
    - halt and stall are ignored.
    - branch_en: pc<=branch_addr, halted<=0, go to RUN, if_valid<=0.
    - Only reset or branch_en leaves HALT.
- Latency: an opcode at address A appears on if_* one cycle after rom_addr=A is presented in RUN without stall.
- rom_addr is purely the pc register, with no combinational path from the inputs.

Test Plan:
- Sequential fetch: RESET_VEC=0, ROM = 01 02 C5 AA 03. Release reset.
  - Required: BOOT cycle with if_valid=0.
  - Then if_pc = 0, 1, 2, 4 on consecutive cycles.
  - At if_pc=2: if_imm=AA, if_has_imm=1, if_next_pc=4.
- Stall: assert stall for 3 cycles while if_pc=1.
  - Required: rom_addr and all if_* outputs unchanged for 3 cycles.
  - Resumes with if_pc=2 on the cycle after stall drops.
- Branch: branch_en=1, branch_addr=8'h40 while stall=1.
  - Required: next cycle rom_addr=40 and if_valid=0.
  - The cycle after that, if_pc=40 and if_valid=1.
- Wrap-around:
  - C0 at address FF, rom[0]=7E: required if_imm=7E, if_has_imm=1, next pc=01, if_next_pc=01.
  - 01 at FF: required next pc=00.
- Halt/resume: pulse halt.
  - Required: halted=1 and if_valid=0 the next cycle; pc frozen for 10 cycles despite stall toggling.
  - Then branch_en with addr=10: required halted=0, rom_addr=10.
- Async reset mid-run: assert rst between clock edges at pc=23.
  - Required: rom_addr=RESET_VEC and if_valid=0 immediately, before any clock edge.
  - After release, a BOOT bubble precedes the first valid fetch.
